pc_sequencer: RTL and testbench

//  Program-counter controller for the CSE141L core. Owns the PC register and sequences it: sequential fetch,

---
 rtl/pc_pkg.sv | 29 ++
 rtl/pc_sequencer_branch_target_table.sv | 35 +++
 rtl/pc_sequencer.sv | 118 +++++++++++
 tb/tb_pc_sequencer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter sequencer and its
// branch target table.
package pc_pkg;

  // Sequencer operating states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_t;

  // The target table is indexed by the 3-bit how_high field, so it has
  // exactly eight entries.
  localparam int N_TGT     = 8;
  localparam int TGT_IDX_W = 3;

  // Power-on branch offsets, two's complement. The table truncates them to
  // its own width on reset.
  localparam int TGT_DEFAULT [N_TGT] = '{2, 10, 22, -30, 314, -316, 346, -352};

  // 16-bit saturating increment used by the taken-branch counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    if (value == 16'hFFFF) begin
      return value;
    end
    return value + 16'd1;
  endfunction

endpackage

// File: rtl/pc_sequencer_branch_target_table.sv
// Runtime-loadable branch offset table: N_TGT entries of D bits, async
// reset to the default offsets, one write port, one combinational read port.
module branch_target_table
  import pc_pkg::*;
#(
  parameter int D = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [TGT_IDX_W-1:0] waddr,
  input  logic [D-1:0]         wdata,
  input  logic [TGT_IDX_W-1:0] raddr,
  output logic [D-1:0]         rdata
);

  logic [D-1:0] mem [N_TGT];

  // Entry storage: defaults on reset, otherwise a single write per edge.
  // Whether a write is allowed at all is decided by the sequencer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_TGT; i++) begin
        mem[i] <= D'(TGT_DEFAULT[i]);
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read is purely combinational so a branch sees the offset in the same
  // cycle that how_high is presented.
  assign rdata = mem[raddr];

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter controller: owns the PC register and steps it through
// sequential fetch, relative branches via the target table, stall and halt.
// The FSM state is exported on fsm_state so checkers can observe it.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int D        = 12,
  parameter int START_PC = 0
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 start,
  input  logic                 stall,
  input  logic                 halt_in,
  input  logic                 branch_en,
  input  logic                 branch_taken,
  input  logic [TGT_IDX_W-1:0] how_high,
  input  logic                 cfg_we,
  input  logic [TGT_IDX_W-1:0] cfg_addr,
  input  logic [D-1:0]         cfg_data,
  output logic [D-1:0]         prog_ctr,
  output logic                 running,
  output logic                 done,
  output logic [15:0]          br_count,
  output logic [1:0]           fsm_state
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_RUN  = RUN;
  localparam logic [1:0] S_HALT = HALT;

  localparam logic [D-1:0] START_ADDR = D'(START_PC);

  logic [1:0]   state;
  logic [1:0]   state_n;
  logic [D-1:0] pc_n;
  logic [15:0]  br_n;
  logic [D-1:0] tgt_off;
  logic         tbl_we;

  // The table may only be reconfigured while the core is not executing;
  // writes attempted during RUN are silently dropped.
  assign tbl_we = cfg_we && (state != S_RUN);

  branch_target_table #(
    .D (D)
  ) u_tgt (
    .clk   (Clk),
    .rst_n (Reset_n),
    .we    (tbl_we),
    .waddr (cfg_addr),
    .wdata (cfg_data),
    .raddr (how_high),
    .rdata (tgt_off)
  );

  // Next-state and next-PC selection. In RUN the priority is
  // stall > halt > taken branch > sequential increment. PC arithmetic is
  // D bits wide with the carry dropped, so it wraps naturally.
  always_comb begin
    state_n = state;
    pc_n    = prog_ctr;
    br_n    = br_count;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_RUN;
          pc_n    = START_ADDR;
          br_n    = 16'd0;
        end
      end
      S_RUN: begin
        if (stall) begin
          // Everything frozen; halt and branch inputs are ignored.
          state_n = S_RUN;
        end else if (halt_in) begin
          // PC stays on the halt instruction.
          state_n = S_HALT;
        end else if (branch_en && branch_taken) begin
          pc_n = prog_ctr + tgt_off;
          br_n = sat_inc16(br_count);
        end else begin
          pc_n = prog_ctr + D'(1);
        end
      end
      S_HALT: begin
        if (start) begin
          state_n = S_RUN;
          pc_n    = START_ADDR;
          br_n    = 16'd0;
        end
      end
      default: begin
        state_n = S_IDLE;
        pc_n    = START_ADDR;
        br_n    = 16'd0;
      end
    endcase
  end

  // State, PC and branch counter registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= S_IDLE;
      prog_ctr <= START_ADDR;
      br_count <= 16'd0;
    end else begin
      state    <= state_n;
      prog_ctr <= pc_n;
      br_count <= br_n;
    end
  end

  assign running   = (state == S_RUN);
  assign done      = (state == S_HALT);
  assign fsm_state = state;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: each driven cycle pushes the expected PC
// onto a queue, which is popped and compared once the edge has happened.
module tb_pc_sequencer;

  localparam int D = 12;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  logic          Clk;
  logic          Reset_n;
  logic          start;
  logic          stall;
  logic          halt_in;
  logic          branch_en;
  logic          branch_taken;
  logic [2:0]    how_high;
  logic          cfg_we;
  logic [2:0]    cfg_addr;
  logic [D-1:0]  cfg_data;
  logic [D-1:0]  prog_ctr;
  logic          running;
  logic          done;
  logic [15:0]   br_count;
  logic [1:0]    fsm_state;

  logic [D-1:0]  exp_q [$];
  logic [D-1:0]  pc_m;
  int            n_cmp;
  int            n_err;

  pc_sequencer #(
    .D        (D),
    .START_PC (0)
  ) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .start        (start),
    .stall        (stall),
    .halt_in      (halt_in),
    .branch_en    (branch_en),
    .branch_taken (branch_taken),
    .how_high     (how_high),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_data     (cfg_data),
    .prog_ctr     (prog_ctr),
    .running      (running),
    .done         (done),
    .br_count     (br_count),
    .fsm_state    (fsm_state)
  );

  // Clock.
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    start = 0; stall = 0; halt_in = 0; branch_en = 0; branch_taken = 0;
    how_high = 0; cfg_we = 0; cfg_addr = 0; cfg_data = 0;
  endtask

  // One clock of stimulus: apply inputs, queue the expected PC, let the
  // edge happen, then pop and compare 1 time unit later.
  task automatic drive(input string tag, input logic s, input logic st, input logic h,
                       input logic be, input logic bt, input logic [2:0] hh,
                       input logic we, input logic [2:0] wa, input logic [D-1:0] wd,
                       input logic [D-1:0] exp_pc);
    logic [D-1:0] e;
    start = s; stall = st; halt_in = h; branch_en = be; branch_taken = bt;
    how_high = hh; cfg_we = we; cfg_addr = wa; cfg_data = wd;
    exp_q.push_back(exp_pc);
    @(posedge Clk);
    #1;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      check(tag, 32'(prog_ctr), 32'(e));
    end
    pc_m = exp_pc;
    clear_inputs();
  endtask

  task automatic inc(input string tag);
    drive(tag, 0, 0, 0, 0, 0, 3'd0, 0, 3'd0, '0, pc_m + 12'd1);
  endtask

  task automatic taken(input string tag, input logic [2:0] hh, input logic [D-1:0] off);
    drive(tag, 0, 0, 0, 1, 1, hh, 0, 3'd0, '0, pc_m + off);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    pc_m  = '0;
    clear_inputs();
    Reset_n = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    check("rst_pc",      32'(prog_ctr),  32'h0);
    check("rst_running", 32'(running),   32'h0);
    check("rst_done",    32'(done),      32'h0);
    check("rst_brcnt",   32'(br_count),  32'h0);
    check("rst_state",   32'(fsm_state), 32'(ST_IDLE));
    Reset_n = 1'b1;

    // Start and sequential fetch 0..5.
    drive("start", 1, 0, 0, 0, 0, 3'd0, 0, 3'd0, '0, 12'd0);
    for (int i = 0; i < 5; i++) inc("seq");
    check("seq_pc5",   32'(prog_ctr), 32'd5);
    check("seq_run",   32'(running),  32'h1);
    check("seq_done",  32'(done),     32'h0);
    check("seq_state", 32'(fsm_state), 32'(ST_RUN));

    // Walk to 20; a start pulse in RUN at PC=10 behaves like a plain fetch.
    for (int i = 0; i < 5; i++) inc("seq");
    drive("start_in_run", 1, 0, 0, 0, 0, 3'd0, 0, 3'd0, '0, 12'd11);
    for (int i = 0; i < 9; i++) inc("seq");
    check("pc20", 32'(prog_ctr), 32'd20);

    // Negative offset: 20 - 30 wraps to 4086.
    taken("br_neg", 3'd3, 12'hFE2);
    check("br_neg_pc", 32'(prog_ctr), 32'hFF6);
    check("br_cnt1",   32'(br_count), 32'd1);
    drive("untaken", 0, 0, 0, 1, 0, 3'd3, 0, 3'd0, '0, 12'd4087);
    check("br_cnt_hold", 32'(br_count), 32'd1);

    // Halt, restart, then untaken branch at PC=20 -> 21.
    drive("halt", 0, 0, 1, 0, 0, 3'd0, 0, 3'd0, '0, 12'd4087);
    check("halt_done",  32'(done),    32'h1);
    check("halt_run",   32'(running), 32'h0);
    drive("restart", 1, 0, 0, 0, 0, 3'd0, 0, 3'd0, '0, 12'd0);
    check("restart_br", 32'(br_count), 32'd0);
    for (int i = 0; i < 20; i++) inc("seq");
    drive("untaken20", 0, 0, 0, 1, 0, 3'd3, 0, 3'd0, '0, 12'd21);

    // Wrap 4095 -> 0 and 4095 + 2 -> 1.
    taken("br_to4087", 3'd3, 12'hFE2);
    for (int i = 0; i < 8; i++) inc("seq");
    check("pc4095", 32'(prog_ctr), 32'd4095);
    inc("wrap_inc");
    check("wrap_inc_pc", 32'(prog_ctr), 32'd0);
    taken("br_to4066", 3'd3, 12'hFE2);
    for (int i = 0; i < 29; i++) inc("seq");
    taken("wrap_br", 3'd0, 12'd2);
    check("wrap_br_pc", 32'(prog_ctr), 32'd1);
    check("br_cnt3",    32'(br_count), 32'd3);
    drive("untaken2", 0, 0, 0, 1, 0, 3'd0, 0, 3'd0, '0, 12'd2);
    check("br_cnt3b",   32'(br_count), 32'd3);

    // Stall beats halt and branch.
    drive("stall", 0, 1, 1, 1, 1, 3'd1, 0, 3'd0, '0, 12'd2);
    check("stall_state", 32'(fsm_state), 32'(ST_RUN));
    check("stall_br",    32'(br_count),  32'd3);
    drive("halt2", 0, 0, 1, 0, 0, 3'd0, 0, 3'd0, '0, 12'd2);
    check("halt2_done",  32'(done), 32'h1);
    drive("halt_hold", 0, 0, 0, 1, 1, 3'd1, 0, 3'd0, '0, 12'd2);
    check("halt_hold_state", 32'(fsm_state), 32'(ST_HALT));
    drive("restart2", 1, 0, 0, 0, 0, 3'd0, 0, 3'd0, '0, 12'd0);
    check("restart2_br",   32'(br_count), 32'd0);
    check("restart2_run",  32'(running),  32'h1);
    check("restart2_done", 32'(done),     32'h0);

    // Table write together with start in HALT; write in RUN is dropped.
    for (int i = 0; i < 10; i++) inc("seq");
    drive("halt3", 0, 0, 1, 0, 0, 3'd0, 0, 3'd0, '0, 12'd10);
    drive("wr_start", 1, 0, 0, 0, 0, 3'd0, 1, 3'd2, 12'hFFB, 12'd0);
    for (int i = 0; i < 10; i++) inc("seq");
    taken("br_new", 3'd2, 12'hFFB);
    check("br_new_pc", 32'(prog_ctr), 32'd5);
    drive("wr_in_run", 0, 0, 0, 0, 0, 3'd0, 1, 3'd2, 12'd100, 12'd6);
    taken("br_keep", 3'd2, 12'hFFB);
    check("br_keep_pc", 32'(prog_ctr), 32'd1);
    check("br_cnt2",    32'(br_count), 32'd2);

    // Counter saturation: 65535 more taken branches from a count of 2.
    for (int i = 0; i < 65535; i++) taken("sat_br", 3'd0, 12'd2);
    check("br_sat", 32'(br_count), 32'hFFFF);

    // Async reset mid-RUN restores the table defaults.
    #2;
    Reset_n = 1'b0;
    #1;
    check("arst_pc",    32'(prog_ctr),  32'h0);
    check("arst_state", 32'(fsm_state), 32'(ST_IDLE));
    check("arst_br",    32'(br_count),  32'h0);
    check("arst_run",   32'(running),   32'h0);
    check("arst_done",  32'(done),      32'h0);
    #2;
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;
    drive("start3", 1, 0, 0, 0, 0, 3'd0, 0, 3'd0, '0, 12'd0);
    taken("br_default", 3'd2, 12'd22);
    check("br_default_pc", 32'(prog_ctr), 32'd22);
    check("br_default_cnt", 32'(br_count), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
